cache_control: RTL and testbench
================================

# cache_control

Sequencing FSM for the direct-mapped L1 cache datapath: 8 sets, 32-byte lines, 24-bit tag, 3-bit index, 5-bit offset. It sits between the CPU memory port and physical memory, and drives the dirty/valid/tag load strobes, the per-byte line write mask and the datapath mux selects. It consumes hit/dirty/valid status from the datapath. It resolves hits, write-backs of dirty victims and line fills, then answers the CPU with a single-cycle `mem_resp`.

## Interface
Parameters:
- none; geometry is fixed by package constants.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mem_read`  in  1  CPU read request, held until `mem_resp`.
- `mem_write`  in  1  CPU write request, held until `mem_resp`.
- `mem_byte_enable`  in  4  CPU write byte lanes.
- `word_offset`  in  3  `mem_address[4:2]`.
- `hit`  in  1  datapath: `valid_out` && tag match.
- `valid_out`  in  1  valid bit of the indexed set.
- `dirty_out`  in  1  dirty bit of the indexed set.
- `pmem_resp`  in  1  physical memory done, 1-cycle pulse.
- `mem_resp`  out  1  CPU response, 1-cycle pulse.
- `pmem_read`  out  1  line-fill request.
- `pmem_write`  out  1  write-back request.
- `ld_dirty`, `ld_valid`, `ld_tag`  out  1 each  array load strobes.
- `dirty_in`, `valid_in`  out  1 each  array write data.
- `write_enable256`  out  32  per-byte line write mask.
- `data_sel`  out  1  0 = CPU word replicated, 1 = pmem line.
- `paddr_sel`  out  1  0 = CPU tag/index, 1 = stored tag/index (victim).

## Operation
- States: IDLE, COMPARE, WRITEBACK, FILL. All outputs are Moore/Mealy combinational from state plus inputs. Every output is 0 when not explicitly driven.
- IDLE: `mem_read|mem_write` -> COMPARE.
- COMPARE:
  - Request deasserted -> IDLE, no response.
  - `hit` -> `mem_resp`=1, then IDLE.
  - Hit on write additionally drives `write_enable256 = mem_byte_enable << (4*word_offset)`, `data_sel`=0, `ld_dirty`=1, `dirty_in`=1.
  - Miss with `valid_out&dirty_out` -> WRITEBACK; otherwise -> FILL.
- WRITEBACK: `pmem_write`=1, `paddr_sel`=1. On `pmem_resp` -> FILL.
- FILL: `pmem_read`=1, `paddr_sel`=0. On `pmem_resp`:
  - `write_enable256`=32'hFFFF_FFFF, `data_sel`=1.
  - `ld_tag`=1; `ld_valid`=1 with `valid_in`=1; `ld_dirty`=1 with `dirty_in`=0.
  - Next state COMPARE, which then hits.
- Both `mem_read` and `mem_write` high: treated as a write.
- `pmem_resp` outside WRITEBACK/FILL: ignored.
- Byte enable 0 on a write hit: mask all zero, but dirty is still set and `mem_resp` still issued.

## Timing
- Reset: state=IDLE, every output 0 asynchronously. Reset mid-WRITEBACK/FILL drops `pmem_read`/`pmem_write` immediately; the line is left unmodified.
- Hit latency: request seen in IDLE at cycle 0 -> `mem_resp` in cycle 1.
- Clean miss: FILL from cycle 2. The `pmem_resp` cycle N writes the arrays; `mem_resp` follows in cycle N+1.
- Dirty miss: WRITEBACK from cycle 2, then FILL starts the cycle after the write-back `pmem_resp`.
- `pmem_read`/`pmem_write` stay high until and including the `pmem_resp` cycle; they are never high together.
- CPU must hold address and data stable until `mem_resp`.

## Configuration
- `CACHE_CTRL_PERF_EN` defined: adds outputs `hit_count`, `miss_count`, `wb_count` (each 32 bits, reset 0, wrap at 2^32).
  - A hit is counted only on a first-pass COMPARE hit. A `miss_pending` flag suppresses counting the post-fill re-compare.
  - `miss_count` increments on each COMPARE miss. `wb_count` increments on each WRITEBACK `pmem_resp`.
- Undefined: ports and logic are absent; all other behaviour is identical.

## Structure
- Shared package `cache_types`:
  - state enum;
  - `data_sel`/`paddr_sel` enums;
  - constants `TAG_W`=24, `IDX_W`=3, `OFF_W`=5, `LINE_BYTES`=32.
- Sub-module `cache_perf_counters` (counters plus `miss_pending`), instantiated only under `CACHE_CTRL_PERF_EN`.

## Test plan
- Cold read, set 3 invalid -> FILL, `pmem_read` until `pmem_resp`; `ld_tag`/`ld_valid`/`ld_dirty` pulse with `valid_in`=1, `dirty_in`=0; `mem_resp` one cycle later.
- Read hit -> `mem_resp` in cycle 1, no pmem activity, all load strobes 0.
- Write hit, `word_offset`=5, `mem_byte_enable`=4'b0110 -> `write_enable256`=32'h0060_0000, `ld_dirty`=1, `dirty_in`=1.
- Miss on dirty valid set -> `pmem_write` with `paddr_sel`=1, then `pmem_read` with `paddr_sel`=0, then `mem_resp`. With perf enabled: `miss_count`=1, `wb_count`=1, `hit_count` unchanged.
- `rst` asserted mid-FILL -> `pmem_read`=0 in the same cycle, state IDLE, no array load strobes.
- `mem_read` dropped in COMPARE on a miss -> IDLE, no `mem_resp`, no pmem request.

Source files
------------

// File: rtl/cache_control_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_types (package)
// Description : Shared types and geometry for the direct-mapped L1 cache
//               controller: FSM state encoding, datapath mux select
//               encodings, cache geometry constants and the write-mask helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_types;

  // Cache geometry: 8 sets of 32-byte lines, 32-bit physical address.
  localparam int TAG_W      = 24;
  localparam int IDX_W      = 3;
  localparam int OFF_W      = 5;
  localparam int LINE_BYTES = 32;

  // The CPU works in 32-bit words, so the word offset drops the byte bits.
  localparam int WORD_OFF_W = OFF_W - 2;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COMPARE   = 2'd1,
    ST_WRITEBACK = 2'd2,
    ST_FILL      = 2'd3
  } state_e;

  // Line data source: the CPU word replicated across the line, or a pmem line.
  typedef enum logic {
    DSEL_CPU  = 1'b0,
    DSEL_PMEM = 1'b1
  } data_sel_e;

  // Physical address source: the CPU request, or the stored victim tag/index.
  typedef enum logic {
    PSEL_CPU    = 1'b0,
    PSEL_VICTIM = 1'b1
  } paddr_sel_e;

  // Places the four CPU byte lanes at the addressed word within the line.
  function automatic logic [LINE_BYTES-1:0] byte_mask(
    input logic [3:0]            be,
    input logic [WORD_OFF_W-1:0] word_off
  );
    return {{(LINE_BYTES-4){1'b0}}, be} << {word_off, 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/cache_control_perf_counters.sv
`default_nettype none
// ============================================================================
// Module      : cache_perf_counters
// Description : Hit / miss / write-back event counters for cache_control.
//               Only instantiated when CACHE_CTRL_PERF_EN is defined.
//               miss_pending marks that the next COMPARE is the re-compare
//               after a line fill, so its hit is not counted again.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_perf_counters (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_compare,
  input  logic        req,
  input  logic        hit,
  input  logic        wb_done,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count,
  output logic [31:0] wb_count
);

  logic [31:0] hit_count_q,  hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;
  logic [31:0] wb_count_q,   wb_count_d;
  logic        miss_pending_q, miss_pending_d;

  // Next-count logic; counters wrap naturally at 2^32.
  always_comb begin
    hit_count_d    = hit_count_q;
    miss_count_d   = miss_count_q;
    wb_count_d     = wb_count_q;
    miss_pending_d = miss_pending_q;
    if (in_compare) begin
      if (!req) begin
        miss_pending_d = 1'b0;
      end else if (hit) begin
        if (!miss_pending_q) begin
          hit_count_d = hit_count_q + 32'd1;
        end
        miss_pending_d = 1'b0;
      end else begin
        miss_count_d   = miss_count_q + 32'd1;
        miss_pending_d = 1'b1;
      end
    end
    if (wb_done) begin
      wb_count_d = wb_count_q + 32'd1;
    end
  end

  // Counter and flag registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_count_q    <= 32'd0;
      miss_count_q   <= 32'd0;
      wb_count_q     <= 32'd0;
      miss_pending_q <= 1'b0;
    end else begin
      hit_count_q    <= hit_count_d;
      miss_count_q   <= miss_count_d;
      wb_count_q     <= wb_count_d;
      miss_pending_q <= miss_pending_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
  assign wb_count   = wb_count_q;

endmodule
`default_nettype wire

// File: rtl/cache_control.sv
`default_nettype none
// ============================================================================
// Module      : cache_control
// Description : Sequencing FSM for the direct-mapped L1 cache. Resolves hits,
//               writes back dirty victims, fills lines from physical memory
//               and answers the CPU with a single-cycle mem_resp. All outputs
//               decode from the state register, so reset forces them low
//               immediately.
//               Optional: define CACHE_CTRL_PERF_EN to add the hit_count,
//               miss_count and wb_count performance outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_control
  import cache_types::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [3:0]            mem_byte_enable,
  input  logic [WORD_OFF_W-1:0] word_offset,
  input  logic                  hit,
  input  logic                  valid_out,
  input  logic                  dirty_out,
  input  logic                  pmem_resp,
`ifdef CACHE_CTRL_PERF_EN
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count,
  output logic [31:0]           wb_count,
`endif
  output logic                  mem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic                  ld_dirty,
  output logic                  ld_valid,
  output logic                  ld_tag,
  output logic                  dirty_in,
  output logic                  valid_in,
  output logic [LINE_BYTES-1:0] write_enable256,
  output logic                  data_sel,
  output logic                  paddr_sel
);

  state_e state_q, state_d;
  logic   req;

  // A simultaneous read and write is handled as a write.
  assign req = mem_read | mem_write;

  // Next-state and output decode; every output defaults low.
  always_comb begin
    state_d         = state_q;
    mem_resp        = 1'b0;
    pmem_read       = 1'b0;
    pmem_write      = 1'b0;
    ld_dirty        = 1'b0;
    ld_valid        = 1'b0;
    ld_tag          = 1'b0;
    dirty_in        = 1'b0;
    valid_in        = 1'b0;
    write_enable256 = '0;
    data_sel        = DSEL_CPU;
    paddr_sel       = PSEL_CPU;
    unique case (state_q)
      ST_IDLE: begin
        if (req) state_d = ST_COMPARE;
      end
      ST_COMPARE: begin
        if (!req) begin
          state_d = ST_IDLE;
        end else if (hit) begin
          mem_resp = 1'b1;
          state_d  = ST_IDLE;
          if (mem_write) begin
            // Dirty is set even when no byte lane is enabled.
            write_enable256 = byte_mask(mem_byte_enable, word_offset);
            data_sel        = DSEL_CPU;
            ld_dirty        = 1'b1;
            dirty_in        = 1'b1;
          end
        end else if (valid_out && dirty_out) begin
          state_d = ST_WRITEBACK;
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_WRITEBACK: begin
        pmem_write = 1'b1;
        paddr_sel  = PSEL_VICTIM;
        if (pmem_resp) state_d = ST_FILL;
      end
      ST_FILL: begin
        pmem_read = 1'b1;
        paddr_sel = PSEL_CPU;
        if (pmem_resp) begin
          // Install the whole line as clean and valid, then re-compare.
          write_enable256 = '1;
          data_sel        = DSEL_PMEM;
          ld_tag          = 1'b1;
          ld_valid        = 1'b1;
          valid_in        = 1'b1;
          ld_dirty        = 1'b1;
          dirty_in        = 1'b0;
          state_d         = ST_COMPARE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with asynchronous reset to IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

`ifdef CACHE_CTRL_PERF_EN
  cache_perf_counters u_perf (
    .clk        (clk),
    .rst        (rst),
    .in_compare (state_q == ST_COMPARE),
    .req        (req),
    .hit        (hit),
    .wb_done    ((state_q == ST_WRITEBACK) && pmem_resp),
    .hit_count  (hit_count),
    .miss_count (miss_count),
    .wb_count   (wb_count)
  );
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_control
// Description : Self-checking bench for cache_control. The bench owns the
//               tag/valid/dirty arrays, plays the datapath and physical
//               memory, and predicts the controller's outputs per cycle
//               from a transaction-level view of each CPU request.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_control;

  typedef struct packed {
    logic        mem_resp;
    logic        pmem_read;
    logic        pmem_write;
    logic        ld_dirty;
    logic        ld_valid;
    logic        ld_tag;
    logic        dirty_in;
    logic        valid_in;
    logic        data_sel;
    logic        paddr_sel;
    logic [31:0] we;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write, hit, valid_out, dirty_out, pmem_resp;
  logic [3:0]  mem_byte_enable;
  logic [2:0]  word_offset;
  logic        mem_resp, pmem_read, pmem_write, ld_dirty, ld_valid, ld_tag;
  logic        dirty_in, valid_in, data_sel, paddr_sel;
  logic [31:0] write_enable256;
`ifdef CACHE_CTRL_PERF_EN
  logic [31:0] hit_count, miss_count, wb_count;
  int          m_hits, m_misses, m_wbs;
`endif

  cache_control dut (
    .clk             (clk),
    .rst             (rst),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .word_offset     (word_offset),
    .hit             (hit),
    .valid_out       (valid_out),
    .dirty_out       (dirty_out),
    .pmem_resp       (pmem_resp),
`ifdef CACHE_CTRL_PERF_EN
    .hit_count       (hit_count),
    .miss_count      (miss_count),
    .wb_count        (wb_count),
`endif
    .mem_resp        (mem_resp),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .ld_dirty        (ld_dirty),
    .ld_valid        (ld_valid),
    .ld_tag          (ld_tag),
    .dirty_in        (dirty_in),
    .valid_in        (valid_in),
    .write_enable256 (write_enable256),
    .data_sel        (data_sel),
    .paddr_sel       (paddr_sel)
  );

  always #5 clk = ~clk;

  // Bench-side cache arrays (the datapath the controller talks to).
  logic        m_valid [8];
  logic        m_dirty [8];
  logic [23:0] m_tag   [8];

  // Address and lanes of the request in flight, applied at each drive.
  int          p_set;
  logic [23:0] p_tag;
  logic [3:0]  p_be;
  logic [2:0]  p_off;

  int   n_pass  = 0;
  int   n_total = 0;
  exp_t expq[$];
  exp_t act;

  localparam logic [23:0] TA = 24'h00A11C;
  localparam logic [23:0] TB = 24'h0B0B0B;
  localparam logic [23:0] TC = 24'hC0FFEE;

  assign act = {mem_resp, pmem_read, pmem_write, ld_dirty, ld_valid, ld_tag,
                dirty_in, valid_in, data_sel, paddr_sel, write_enable256};

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, want, $time);
  endtask

  // Expected output patterns, built from the controller's documented rules.
  function automatic exp_t e_wb();
    exp_t e = '0;
    e.pmem_write = 1'b1;
    e.paddr_sel  = 1'b1;
    return e;
  endfunction

  function automatic exp_t e_fill(input bit done);
    exp_t e = '0;
    e.pmem_read = 1'b1;
    if (done) begin
      e.we       = 32'hFFFF_FFFF;
      e.data_sel = 1'b1;
      e.ld_tag   = 1'b1;
      e.ld_valid = 1'b1;
      e.valid_in = 1'b1;
      e.ld_dirty = 1'b1;
    end
    return e;
  endfunction

  function automatic exp_t e_resp(input bit wr, input logic [3:0] be, input logic [2:0] off);
    exp_t e = '0;
    e.mem_resp = 1'b1;
    if (wr) begin
      e.we       = 32'(be) << (4 * int'(off));
      e.ld_dirty = 1'b1;
      e.dirty_in = 1'b1;
    end
    return e;
  endfunction

  // One clock of stimulus: apply inputs just after the edge, queue the prediction.
  task automatic drive(input logic rd, input logic wr, input logic pr, input exp_t e);
    @(posedge clk);
    #1;
    mem_read        = rd;
    mem_write       = wr;
    pmem_resp       = pr;
    mem_byte_enable = p_be;
    word_offset     = p_off;
    valid_out       = m_valid[p_set];
    dirty_out       = m_dirty[p_set];
    hit             = m_valid[p_set] && (m_tag[p_set] == p_tag);
    expq.push_back(e);
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  // Compare the DUT against the prediction for every driven cycle.
  always @(negedge clk) begin
    if (expq.size() > 0) check("outputs", 64'(act), 64'(expq.pop_front()));
  end

  // One complete CPU request; chk selects extra literal checks.
  task automatic txn(input bit rd, input bit wr, input int set, input logic [23:0] tag,
                     input logic [3:0] be, input logic [2:0] off, input bit drop,
                     input int w1, input int w2, input int chk);
    bit is_wr = wr;
    bit h;
    p_set = set; p_tag = tag; p_be = be; p_off = off;
    h = m_valid[set] && (m_tag[set] == tag);
    drive(rd, wr, 1'($urandom % 2), '0);
    if (drop) begin
      drive(1'b0, 1'b0, 1'($urandom % 2), '0);
      return;
    end
    if (h) begin
`ifdef CACHE_CTRL_PERF_EN
      m_hits++;
`endif
      drive(rd, wr, 1'($urandom % 2), e_resp(is_wr, be, off));
      if (chk == 2) begin
        at_neg();
        check("hit resp", 64'(mem_resp), 64'd1);
        check("hit quiet", 64'({pmem_read, pmem_write, ld_tag, ld_valid, ld_dirty}), 64'd0);
      end
      if (chk == 3) begin
        at_neg();
        check("write mask", 64'(write_enable256), 64'h0060_0000);
        check("write dirty", 64'({ld_dirty, dirty_in}), 64'b11);
      end
      if (is_wr) m_dirty[set] = 1'b1;
      return;
    end
    drive(rd, wr, 1'($urandom % 2), '0);
`ifdef CACHE_CTRL_PERF_EN
    m_misses++;
`endif
    if (m_valid[set] && m_dirty[set]) begin
      for (int i = 0; i <= w1; i++) begin
        drive(rd, wr, 1'(i == w1), e_wb());
        if (chk == 4 && i == 0) begin
          at_neg();
          check("wb select", 64'({pmem_write, pmem_read, paddr_sel}), 64'b101);
        end
      end
`ifdef CACHE_CTRL_PERF_EN
      m_wbs++;
`endif
    end
    for (int i = 0; i <= w2; i++) begin
      drive(rd, wr, 1'(i == w2), e_fill(i == w2));
      if (chk == 4 && i == 0) begin
        at_neg();
        check("fill select", 64'({pmem_read, pmem_write, paddr_sel}), 64'b100);
      end
      if (chk == 1 && i == w2) begin
        at_neg();
        check("fill strobes", 64'({ld_tag, ld_valid, valid_in, ld_dirty, dirty_in}), 64'b11110);
      end
    end
    m_valid[set] = 1'b1;
    m_dirty[set] = 1'b0;
    m_tag[set]   = tag;
    drive(rd, wr, 1'($urandom % 2), e_resp(is_wr, be, off));
    if (chk == 1) begin
      at_neg();
      check("miss resp", 64'(mem_resp), 64'd1);
    end
    if (is_wr) m_dirty[set] = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
    hit = 1'b0; valid_out = 1'b0; dirty_out = 1'b0;
    mem_byte_enable = 4'h0; word_offset = 3'd0;
    p_set = 0; p_tag = TA; p_be = 4'h0; p_off = 3'd0;
    for (int i = 0; i < 8; i++) begin
      m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = 24'h0;
    end
`ifdef CACHE_CTRL_PERF_EN
    m_hits = 0; m_misses = 0; m_wbs = 0;
`endif
    #12;
    check("reset outputs", 64'(act), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Cold read to invalid set 3, then read hit, then write hit.
    txn(1'b1, 1'b0, 3, TA, 4'h0, 3'd0, 1'b0, 0, 2, 1);
    txn(1'b1, 1'b0, 3, TA, 4'h0, 3'd2, 1'b0, 0, 0, 2);
    txn(1'b0, 1'b1, 3, TA, 4'b0110, 3'd5, 1'b0, 0, 0, 3);
    // Conflicting tag on the now-dirty set 3: write-back, fill, respond.
    txn(1'b1, 1'b0, 3, TB, 4'h0, 3'd1, 1'b0, 2, 1, 4);
`ifdef CACHE_CTRL_PERF_EN
    at_neg();
    check("perf hits", 64'(hit_count), 64'd2);
    check("perf misses", 64'(miss_count), 64'd2);
    check("perf wbs", 64'(wb_count), 64'd1);
`endif
    // Request withdrawn during COMPARE on a miss; following cycles stay quiet.
    txn(1'b1, 1'b0, 5, TA, 4'h0, 3'd0, 1'b1, 0, 0, 0);
    drive(1'b0, 1'b0, 1'b1, '0);
    drive(1'b0, 1'b0, 1'b0, '0);

    // Reset in the middle of a fill of set 6.
    p_set = 6; p_tag = TC; p_be = 4'h0; p_off = 3'd0;
    drive(1'b1, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b0, e_fill(1'b0));
    at_neg();
    rst = 1'b1;
    #1;
    check("rst drops pmem_read", 64'(pmem_read), 64'd0);
    check("rst all outputs", 64'(act), 64'd0);
    @(posedge clk);
    #1;
    check("rst no strobes", 64'({ld_tag, ld_valid, ld_dirty}), 64'd0);
    mem_read = 1'b0;
    rst = 1'b0;
`ifdef CACHE_CTRL_PERF_EN
    m_hits = 0; m_misses = 0; m_wbs = 0;
`endif

    // Randomised traffic over all sets with a few competing tags.
    for (int n = 0; n < 120; n++) begin
      int          kind, sel;
      logic [23:0] tg;
      kind = int'($urandom % 4);
      sel  = int'($urandom % 3);
      tg   = (sel == 0) ? TA : (sel == 1) ? TB : TC;
      txn((kind != 1), (kind == 1 || kind == 2), int'($urandom % 8), tg,
          4'($urandom), 3'($urandom), ($urandom % 8) == 0,
          int'($urandom % 4), int'($urandom % 4), 0);
      if ($urandom % 3 == 0) drive(1'b0, 1'b0, 1'($urandom % 2), '0);
    end
    drive(1'b0, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b0, '0);
    at_neg();
`ifdef CACHE_CTRL_PERF_EN
    check("perf hits end", 64'(hit_count), 64'(m_hits));
    check("perf misses end", 64'(miss_count), 64'(m_misses));
    check("perf wbs end", 64'(wb_count), 64'(m_wbs));
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
